stream_demux_1_n: RTL and testbench
===================================

// Module: stream_demux_1_n
//
// PURPOSE
//   1:N demultiplexer for a valid/ready stream; the counterpart of the N:1 data muxes.
//   One upstream channel carries {data, sel}. Each beat is routed to downstream
//   channel sel through a registered 2-entry skid buffer. Order is preserved.
//   Per-channel transfer counters give bench/debug visibility.
//
// PARAMETERS
//   W   4  data width per beat
//   N   4  downstream channel count; power of 2, >= 2; SW = $clog2(N)
//   CW  8  per-channel transfer counter width
//
// PORTS
//   clk         in   1     clock, all state on posedge
//   rst         in   1     synchronous, active-high reset
//   up_valid    in   1     upstream beat valid
//   up_ready    out  1     upstream may transfer (registered)
//   up_data     in   W     beat data (X allowed, carried unchanged)
//   up_sel      in   SW    destination channel index
//   down_valid  out  N     one-hot or zero; bit i = beat for channel i
//   down_ready  in   N     per-channel accept
//   down_data   out  N*W   channel i at [i*W +: W]; zero when channel not valid
//   down_cnt    out  N*CW  channel i transfers completed, wraps modulo 2**CW
//
// BEHAVIOUR
//   - push = up_valid & up_ready; pop = down_valid[hsel] & down_ready[hsel].
//   - Entries: head {hdata,hsel} drives outputs; skid {sdata,ssel} holds 2nd beat.
//   - States EMPTY / ONE / TWO:
//       EMPTY: push -> ONE (beat into head)
//       ONE  : push&pop -> ONE (new beat into head); push only -> TWO (into skid);
//              pop only -> EMPTY; neither -> ONE
//       TWO  : pop -> ONE (skid moves to head); no push possible
//   - up_ready register: next value = (next_state != TWO). Throughput 1 beat/cycle
//     when the head's channel is ready; up_ready never depends combinationally on down_ready.
//   - down_valid[i] = (state != EMPTY) & (hsel == i). down_data slice i = hdata
//     when down_valid[i] else 0. Both are combinational from registers only.
//   - Latency: beat accepted at edge t is visible on down_valid at cycle t+1.
//   - Head-of-line: a stalled head blocks later beats for other channels.
//     down_ready of non-selected channels is ignored.
//   - down_cnt[i] += 1 on each pop with hsel == i; wraps 2**CW-1 -> 0.
//   - up_valid low: up_data and up_sel are don't-care and never captured.
//     Once asserted, up_valid holds until push.
//   - Reset values: state EMPTY, down_valid 0, down_data 0, up_ready 1, all down_cnt 0.
//   - Reset mid-operation: buffered beats are dropped. No down_valid in the cycle
//     after rst. Counters clear.
//   - down_valid is never X after reset, even when data is X.
//
// STRUCTURE
//   - Package stream_demux_pkg:
//       typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t; default N/W/CW.
//   - Sub-module stream_skid_2: generic 2-entry skid buffer over a (W+SW)-bit
//     payload, with registered ready.
//   - Top: skid_2 instance, output decode, generate loop of N counters.
//
// TESTING
//   1 reset: rst=1 for 2 cycles, then release -> up_ready=1, down_valid=0000,
//     all down_cnt=0.
//   2 routing: all down_ready=1111; send {a,0},{b,1},{c,2},{d,3} back-to-back
//     -> down_valid 0001,0010,0100,1000 on consecutive cycles with data a,b,c,d.
//     up_ready stays 1. down_cnt = 1,1,1,1.
//   3 backpressure: down_ready=0000; push {7,2},{3,1} -> second accepted, then
//     up_ready=0. Raise down_ready[2] -> 7 on ch2, then 3 on ch1 after down_ready[1].
//     Order kept, no loss.
//   4 HOL/ignore: head {5,3}, down_ready=0111 -> down_valid=1000 held, no pop.
//     Channels 0..2 see no valid.
//   5 X data: push {x,3} with down_ready=1000 -> down_valid=1000 (not X),
//     data slice 3 = x, down_cnt[3] increments.
//   6 wrap + mid reset: 256 pops on ch0 -> down_cnt[0]=0. Fill TWO, assert rst
//     one cycle -> buffer empty, up_ready=1, counters 0.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types and defaults for the 1:N stream demultiplexer.
package stream_demux_pkg;

    // Default geometry: data width, channel count, transfer counter width.
    localparam int unsigned DEF_W  = 4;
    localparam int unsigned DEF_N  = 4;
    localparam int unsigned DEF_CW = 8;

    // Occupancy of the 2-entry skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    // Upstream may send again only while a free slot remains after this edge.
    function automatic logic ready_after(input skid_state_t next_state);
        logic rdy;
        case (next_state)
            EMPTY:   rdy = 1'b1;
            ONE:     rdy = 1'b1;
            TWO:     rdy = 1'b0;
            default: rdy = 1'b0;
        endcase
        return rdy;
    endfunction

endpackage

// File: rtl/stream_skid_2.sv
// Generic 2-entry skid buffer with a registered upstream ready.
// The head entry is presented downstream; the skid entry absorbs one extra
// beat so that in_ready never depends combinationally on out_ready.
module stream_skid_2
    import stream_demux_pkg::*;
#(
    parameter int unsigned PW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_payload,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_payload
);

    skid_state_t   state_q, state_d;
    logic [PW-1:0] head_q,  head_d;
    logic [PW-1:0] skid_q,  skid_d;
    logic          ready_q, ready_d;
    logic          push_s;
    logic          pop_s;

    // Next-state, entry movement and next ready computation.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        push_s  = in_valid & ready_q;
        pop_s   = (state_q != EMPTY) & out_ready;

        case (state_q)
            EMPTY: begin
                if (push_s) begin
                    head_d  = in_payload;
                    state_d = ONE;
                end else begin
                    state_d = EMPTY;
                end
            end
            ONE: begin
                if (push_s && pop_s) begin
                    head_d  = in_payload;
                    state_d = ONE;
                end else if (push_s) begin
                    skid_d  = in_payload;
                    state_d = TWO;
                end else if (pop_s) begin
                    state_d = EMPTY;
                end else begin
                    state_d = ONE;
                end
            end
            TWO: begin
                // ready is low here, so no push can arrive in this state
                if (pop_s) begin
                    head_d  = skid_q;
                    state_d = ONE;
                end else begin
                    state_d = TWO;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        ready_d = ready_after(state_d);
    end

    // State, entries and ready register; reset drops any buffered beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= {PW{1'b0}};
            skid_q  <= {PW{1'b0}};
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

    assign in_ready    = ready_q;
    assign out_valid   = (state_q != EMPTY);
    assign out_payload = head_q;

endmodule

// File: rtl/stream_demux_1_n.sv
// 1:N valid/ready stream demultiplexer. Each upstream beat {data, sel} is
// buffered in a 2-entry skid buffer and presented on channel sel. Beats leave
// strictly in arrival order, so a stalled head blocks beats for other channels.
module stream_demux_1_n
    import stream_demux_pkg::*;
#(
    parameter int unsigned W  = DEF_W,
    parameter int unsigned N  = DEF_N,
    parameter int unsigned CW = DEF_CW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   up_valid,
    output logic                   up_ready,
    input  logic [W-1:0]           up_data,
    input  logic [$clog2(N)-1:0]   up_sel,
    output logic [N-1:0]           down_valid,
    input  logic [N-1:0]           down_ready,
    output logic [N*W-1:0]         down_data,
    output logic [N*CW-1:0]        down_cnt
);

    localparam int unsigned SW = $clog2(N);
    localparam int unsigned PW = W + SW;
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [PW-1:0] head_payload_s;
    logic          head_valid_s;
    logic [W-1:0]  head_data_s;
    logic [SW-1:0] head_sel_s;
    logic          head_ready_s;
    logic          pop_s;

    // Only the channel addressed by the head can accept; the others are ignored.
    always_comb begin
        head_data_s  = head_payload_s[PW-1:SW];
        head_sel_s   = head_payload_s[SW-1:0];
        head_ready_s = down_ready[head_sel_s];
        pop_s        = head_valid_s & head_ready_s;
    end

    stream_skid_2 #(
        .PW (PW)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (up_valid),
        .in_ready    (up_ready),
        .in_payload  ({up_data, up_sel}),
        .out_valid   (head_valid_s),
        .out_ready   (head_ready_s),
        .out_payload (head_payload_s)
    );

    for (genvar g = 0; g < N; g++) begin : g_chan
        logic          hit_s;
        logic [W-1:0]  data_s;
        logic [CW-1:0] cnt_q, cnt_d;

        // Output decode: valid only for the head's channel, data zeroed elsewhere.
        always_comb begin
            hit_s = head_valid_s & (head_sel_s == SW'(g));
            if (hit_s) begin
                data_s = head_data_s;
            end else begin
                data_s = {W{1'b0}};
            end
        end

        // Transfer counter advances on each completed transfer on this channel.
        always_comb begin
            if (pop_s && hit_s) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end

        // Counter register, cleared by reset, wraps naturally.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= {CW{1'b0}};
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign down_valid[g]           = hit_s;
        assign down_data[g*W +: W]     = data_s;
        assign down_cnt[g*CW +: CW]    = cnt_q;
    end

endmodule

// File: tb/tb_stream_demux_1_n.sv
// Self-checking bench for stream_demux_1_n: directed cases with literal
// expectations, then randomized traffic against a queue-based reference.
module tb_stream_demux_1_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        up_valid;
    logic        up_ready;
    logic [3:0]  up_data;
    logic [1:0]  up_sel;
    logic [3:0]  down_valid;
    logic [3:0]  down_ready;
    logic [15:0] down_data;
    logic [31:0] down_cnt;

    always #5 clk = ~clk;

    stream_demux_1_n #(.W(4), .N(4), .CW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_sel     (up_sel),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data),
        .down_cnt   (down_cnt)
    );

    typedef struct packed {
        logic [3:0] d;
        logic [1:0] s;
    } beat_t;

    // Reference: an ordered FIFO of at most two beats plus per-channel counts.
    beat_t      mq[$];
    logic [7:0] mcnt[4];
    bit         m_ready;
    bit         m_init   = 1'b0;
    bit         m_pushed = 1'b0;
    int         n_vec    = 0;
    int         n_err    = 0;

    // Reference model update on each rising edge.
    always @(posedge clk) begin
        bit    push;
        bit    pop;
        beat_t b;
        if (rst) begin
            mq.delete();
            for (int i = 0; i < 4; i++) mcnt[i] = 8'd0;
            m_ready  = 1'b1;
            m_init   = 1'b1;
            m_pushed = 1'b0;
        end else if (m_init) begin
            push = up_valid && m_ready;
            pop  = (mq.size() > 0) && down_ready[mq[0].s];
            if (pop) begin
                mcnt[mq[0].s] = mcnt[mq[0].s] + 8'd1;
                void'(mq.pop_front());
            end
            if (push) begin
                b.d = up_data;
                b.s = up_sel;
                mq.push_back(b);
            end
            m_ready  = (mq.size() < 2);
            m_pushed = push;
        end
    end

    // Every-cycle comparison of all outputs against the reference.
    always @(negedge clk) begin
        logic [3:0]  ev;
        logic [15:0] ed;
        logic [31:0] ec;
        if (m_init) begin
            ev = 4'b0000;
            ed = 16'h0000;
            if (mq.size() > 0) begin
                ev[mq[0].s]          = 1'b1;
                ed[mq[0].s*4 +: 4]   = mq[0].d;
            end
            for (int i = 0; i < 4; i++) ec[i*8 +: 8] = mcnt[i];
            n_vec++;
            if (up_ready !== m_ready) begin
                n_err++;
                $display("FAIL model_up_ready t=%0t got %b expected %b", $time, up_ready, m_ready);
            end
            if (down_valid !== ev) begin
                n_err++;
                $display("FAIL model_down_valid t=%0t got %b expected %b", $time, down_valid, ev);
            end
            if (down_data !== ed) begin
                n_err++;
                $display("FAIL model_down_data t=%0t got %h expected %h", $time, down_data, ed);
            end
            if (down_cnt !== ec) begin
                n_err++;
                $display("FAIL model_down_cnt t=%0t got %h expected %h", $time, down_cnt, ec);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [3:0] d, input logic [1:0] s);
        up_valid = 1'b1;
        up_data  = d;
        up_sel   = s;
    endtask

    logic [3:0] xval;

    initial begin
        rst        = 1'b1;
        up_valid   = 1'b0;
        up_data    = 4'h0;
        up_sel     = 2'd0;
        down_ready = 4'b0000;
        xval       = 4'bxxxx;

        // 1: reset
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("rst_up_ready", {31'd0, up_ready}, 32'd1);
        chk("rst_down_valid", {28'd0, down_valid}, 32'd0);
        chk("rst_down_cnt", down_cnt, 32'd0);

        // 2: routing, back-to-back at full rate
        down_ready = 4'b1111;
        send(4'hA, 2'd0);
        tick();
        chk("route_v0", {28'd0, down_valid}, 32'h1);
        chk("route_d0", {28'd0, down_data[3:0]}, 32'hA);
        chk("route_rdy", {31'd0, up_ready}, 32'd1);
        send(4'hB, 2'd1);
        tick();
        chk("route_v1", {28'd0, down_valid}, 32'h2);
        chk("route_d1", {28'd0, down_data[7:4]}, 32'hB);
        send(4'hC, 2'd2);
        tick();
        chk("route_v2", {28'd0, down_valid}, 32'h4);
        chk("route_d2", {28'd0, down_data[11:8]}, 32'hC);
        send(4'hD, 2'd3);
        tick();
        chk("route_v3", {28'd0, down_valid}, 32'h8);
        chk("route_d3", {28'd0, down_data[15:12]}, 32'hD);
        up_valid = 1'b0;
        tick();
        chk("route_idle", {28'd0, down_valid}, 32'h0);
        chk("route_cnt", down_cnt, 32'h01010101);

        // 3: backpressure, fill both entries then drain in order
        down_ready = 4'b0000;
        send(4'h7, 2'd2);
        tick();
        send(4'h3, 2'd1);
        tick();
        up_valid = 1'b0;
        chk("bp_full_rdy", {31'd0, up_ready}, 32'd0);
        chk("bp_head_v", {28'd0, down_valid}, 32'h4);
        chk("bp_head_d", {28'd0, down_data[11:8]}, 32'h7);
        tick();
        chk("bp_hold_v", {28'd0, down_valid}, 32'h4);
        down_ready = 4'b0100;
        tick();
        chk("bp_next_v", {28'd0, down_valid}, 32'h2);
        chk("bp_next_d", {28'd0, down_data[7:4]}, 32'h3);
        chk("bp_rdy_back", {31'd0, up_ready}, 32'd1);
        down_ready = 4'b0010;
        tick();
        chk("bp_empty", {28'd0, down_valid}, 32'h0);
        chk("bp_cnt", down_cnt, 32'h01020201);

        // 4: head-of-line, other channels' ready ignored
        down_ready = 4'b0111;
        send(4'h5, 2'd3);
        tick();
        up_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("hol_v", {28'd0, down_valid}, 32'h8);
            chk("hol_low_data", {20'd0, down_data[11:0]}, 32'h0);
            tick();
        end
        chk("hol_cnt", down_cnt, 32'h01020201);
        down_ready = 4'b1000;
        tick();
        chk("hol_drain", {28'd0, down_valid}, 32'h0);

        // 5: unknown data carried, valid stays known
        down_ready = 4'b0000;
        send(xval, 2'd3);
        tick();
        up_valid   = 1'b0;
        chk("x_valid", {28'd0, down_valid}, 32'h8);
        chk("x_data", {28'd0, down_data[15:12]}, {28'd0, xval});
        down_ready = 4'b1000;
        tick();
        chk("x_cnt3", {24'd0, down_cnt[31:24]}, 32'd3);

        // 6: counter wrap after 256 transfers, then reset while full
        rst = 1'b1;
        tick();
        rst = 1'b0;
        down_ready = 4'b0001;
        send(4'h9, 2'd0);
        for (int k = 1; k <= 256; k++) begin
            tick();
            up_data = 4'(k);
        end
        up_valid = 1'b0;
        chk("wrap_255", {24'd0, down_cnt[7:0]}, 32'd255);
        tick();
        chk("wrap_0", {24'd0, down_cnt[7:0]}, 32'd0);
        down_ready = 4'b0000;
        send(4'h1, 2'd1);
        tick();
        send(4'h2, 2'd2);
        tick();
        up_valid = 1'b0;
        chk("fill_rdy", {31'd0, up_ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_rdy", {31'd0, up_ready}, 32'd1);
        chk("mrst_valid", {28'd0, down_valid}, 32'h0);
        chk("mrst_cnt", down_cnt, 32'd0);

        // randomized traffic with occasional reset; up_valid holds until accepted
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) down_ready = 4'b1111;
            else                           down_ready = 4'($urandom);
            if (!(up_valid && !m_pushed)) begin
                up_valid = ($urandom_range(0, 3) != 0);
                up_data  = 4'($urandom);
                up_sel   = 2'($urandom);
            end
        end
        tick();
        rst        = 1'b0;
        up_valid   = 1'b0;
        down_ready = 4'b1111;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
